// File: rtl/csa_accum.sv
// Iterative multi-operand adder: folds a stream of operands into a redundant
// (sum, carry) pair through one 3:2 stage, then resolves with a single add.
module csa_accum #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 start,
    input  logic [CW-1:0]        count,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [DW+CW-1:0]     out_sum,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int RW = DW + CW;

    // Handshakes: a word moves on a port in any cycle where its valid and
    // ready are both high at the rising edge of clk; valid never waits on ready.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   s_q, s_d;
    logic [RW-1:0]   c_q, c_d;
    logic [CW-1:0]   remaining_q, remaining_d;
    logic [RW-1:0]   out_sum_q, out_sum_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [RW-1:0]   x_ext;
    logic [RW-1:0]   csa_sum;
    logic [RW-1:0]   csa_carry;
    logic            accept;
    logic            release_result;

    assign x_ext          = {{CW{1'b0}}, in_data};
    assign accept         = (state_q == ACCUM) && in_valid;
    assign release_result = (state_q == DONE) && out_ready;

    // One 3:2 compressor stage; the carry vector is weighted by 2.
    always_comb begin
        csa_sum   = s_q ^ c_q ^ x_ext;
        csa_carry = ((s_q & c_q) | (c_q & x_ext) | (x_ext & s_q)) << 1;
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        remaining_d = remaining_q;
        out_sum_d   = out_sum_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d         = '0;
                    c_d         = '0;
                    remaining_d = count;
                    state_d     = (count != '0) ? ACCUM : RESOLVE;
                end
            end
            ACCUM: begin
                if (accept) begin
                    s_d         = csa_sum;
                    c_d         = csa_carry;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == {{(CW-1){1'b0}}, 1'b1}) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_sum_d = s_q + c_q;
                state_d   = DONE;
            end
            DONE: begin
                if (release_result) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port flags are decoded from the next state so they leave a flop.
    always_comb begin
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            remaining_q <= '0;
            out_sum_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            remaining_q <= remaining_d;
            out_sum_q   <= out_sum_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
